// File: rtl/hack_pkg.sv
// Shared HACK memory-hierarchy definitions: word width, RAM8 address width, word type.
package hack_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned RAM8_ADDR_W = 3;

    typedef logic [WORD_W-1:0] hack_word_t;

endpackage

// File: rtl/word_reg16.sv
// Single storage word with load enable and asynchronous active-low reset.
module word_reg16
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Capture d on load; clear to zero on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ram8_regbank.sv
// Eight-word register bank: synchronous write, 1-cycle registered read with
// write-first bypass, and per-word written flags for uninitialised-read detection.
module ram8_regbank
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in,
    input  logic [RAM8_ADDR_W-1:0] address,
    input  logic                   load,
    input  logic                   rd_en,
    input  logic                   clear,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    output logic                   out_uninit,
    output logic [DEPTH-1:0]       written
);

    logic [DEPTH-1:0] load_dec;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] out_q, rd_data;
    logic             valid_q, uninit_q, rd_uninit;

    // One-hot load decode of the shared address.
    always_comb begin
        load_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            load_dec[i] = load && (address == RAM8_ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        word_reg16 #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk    (clk),
            .reset_n(reset_n),
            .load   (load_dec[g]),
            .d      (in),
            .q      (mem[g])
        );
    end

    // Read select with write-first bypass; flags sampled before any clear.
    always_comb begin
        rd_data   = mem[address];
        rd_uninit = ~written_q[address];
        if (load) begin
            rd_data   = in;
            rd_uninit = 1'b0;
        end
    end

    // Written flags: clear takes effect first, then a write sets its bit.
    always_comb begin
        written_d = written_q;
        if (clear) begin
            written_d = '0;
        end
        if (load) begin
            written_d[address] = 1'b1;
        end
    end

    // Flag state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    // Read output register; data holds when idle, valid/uninit pulse per read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            valid_q  <= 1'b0;
            uninit_q <= 1'b0;
        end else begin
            valid_q  <= rd_en;
            uninit_q <= rd_en & rd_uninit;
            if (rd_en) begin
                out_q <= rd_data;
            end
        end
    end

    assign out        = out_q;
    assign out_valid  = valid_q;
    assign out_uninit = uninit_q;
    assign written    = written_q;

endmodule

// File: tb/tb_ram8_regbank.sv
// Scoreboard bench for ram8_regbank: reads push expected {uninit, data} at the
// issuing edge, the negedge monitor pops and compares when out_valid is seen.
module tb_ram8_regbank;
    import hack_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in;
    logic [2:0]  address;
    logic        load, rd_en, clear;
    logic [15:0] out;
    logic        out_valid, out_uninit;
    logic [7:0]  written;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] sb [$];
    logic [15:0] m_mem [8];
    logic [7:0]  m_wr;

    ram8_regbank u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .address   (address),
        .load      (load),
        .rd_en     (rd_en),
        .clear     (clear),
        .out       (out),
        .out_valid (out_valid),
        .out_uninit(out_uninit),
        .written   (written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_wr = 8'h00;
    endtask

    // Drive one cycle of stimulus; update the reference model at the edge.
    task automatic step(input logic l, input logic r, input logic c,
                        input logic [2:0] a, input logic [15:0] d);
        load    = l;
        rd_en   = r;
        clear   = c;
        address = a;
        in      = d;
        @(posedge clk);
        if (r) sb.push_back(l ? {1'b0, d} : {~m_wr[a], m_mem[a]});
        if (c) m_wr = 8'h00;
        if (l) begin
            m_mem[a] = d;
            m_wr[a]  = 1'b1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (reset_n === 1'b1) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", 32'(out), 32'(e[15:0]));
                    check("rd_uninit", 32'(out_uninit), 32'(e[16]));
                end
            end else if (sb.size() != 0) begin
                check("missing_valid", 32'(out_valid), 32'd1);
                sb.delete();
            end else begin
                check("idle_uninit", 32'(out_uninit), 32'd0);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        load = 1'b0; rd_en = 1'b0; clear = 1'b0; address = 3'd0; in = 16'h0;
        model_reset();
        #3;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_uninit", 32'(out_uninit), 32'd0);
        check("rst_written", 32'(written), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Read of never-written word after reset.
        step(0, 1, 0, 3'd5, 16'h0);
        check("written_after_rst", 32'(written), 32'h00);
        step(0, 0, 0, 3'd0, 16'h0);

        // Write then read.
        step(1, 0, 0, 3'd3, 16'hBEEF);
        step(0, 1, 0, 3'd3, 16'h0);
        check("written_w3", 32'(written), 32'h08);
        step(0, 0, 0, 3'd0, 16'h0);

        // Read-during-write, write-first; then a plain re-read.
        step(1, 1, 0, 3'd7, 16'h1234);
        step(0, 0, 0, 3'd0, 16'h0);
        step(0, 1, 0, 3'd7, 16'h0);
        step(0, 0, 0, 3'd0, 16'h0);

        // Fill all words, then stream reads back to back.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 3'(i), 16'h1000 + 16'(i));
        check("written_full", 32'(written), 32'hFF);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 3'(i), 16'h0);
        step(0, 0, 0, 3'd0, 16'h0);

        // Clear keeps contents but marks words uninitialised.
        step(0, 0, 1, 3'd0, 16'h0);
        check("written_cleared", 32'(written), 32'h00);
        step(0, 1, 0, 3'd2, 16'h0);
        step(0, 0, 0, 3'd0, 16'h0);
        // Clear together with read reports pre-clear flags.
        step(1, 0, 0, 3'd1, 16'h5555);
        step(0, 1, 1, 3'd1, 16'h0);
        check("written_clr_rd", 32'(written), 32'h00);
        // Clear together with load leaves only that bit.
        step(1, 0, 1, 3'd4, 16'hAAAA);
        check("written_clr_load", 32'(written), 32'h10);
        check("written_model", 32'(written), 32'(m_wr));

        // Asynchronous reset while a read result is on the output.
        step(0, 1, 0, 3'd6, 16'h0);
        check("valid_before_rst", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_written", 32'(written), 32'd0);
        sb.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 1, 0, 3'(i), 16'h0);
        step(0, 0, 0, 3'd0, 16'h0);
        step(0, 0, 0, 3'd0, 16'h0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
